// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector.
// Consumes one bit per cycle when en=1 and raises out (Mealy, same cycle)
// when the last LEN consumed bits equal PATTERN. Also keeps a registered
// sticky found flag and a saturating match counter, both cleared by clear.
module seq_detector_param #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1001,
  parameter bit             OVERLAP = 1'b1,
  parameter bit             STICKY  = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             data,
  input  logic             clear,
  output logic             out,
  output logic             found,
  output logic [CNT_W-1:0] match_count
);

  // fill counts valid history bits and tops out at LEN-1
  localparam int                FILL_W   = $clog2(LEN) + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN - 1);

  logic [LEN-2:0]    hist_reg;
  logic [LEN-2:0]    hist_next;
  logic [LEN-2:0]    hist_shift;
  logic [FILL_W-1:0] fill_reg;
  logic [FILL_W-1:0] fill_next;
  logic              found_reg;
  logic              found_next;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic              match;

  // History shifted by one consumed bit, newest bit entering at position 0.
  // Written per bit so that LEN=2 (single-bit history) needs no special case.
  assign hist_shift[0] = data;
  generate
    for (genvar gi = 1; gi < LEN - 1; gi++) begin : g_shift
      assign hist_shift[gi] = hist_reg[gi-1];
    end
  endgenerate

  // A match needs a full history plus the bit being presented right now
  assign match = en && (fill_reg == FILL_MAX) && ({hist_reg, data} == PATTERN);

  // State register: asynchronous active-low reset drops all history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_reg  <= '0;
      fill_reg  <= '0;
      found_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      hist_reg  <= hist_next;
      fill_reg  <= fill_next;
      found_reg <= found_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic: history advances only on valid bits; clear beats match
  always_comb begin
    hist_next  = hist_reg;
    fill_next  = fill_reg;
    found_next = found_reg;
    count_next = count_reg;
    if (en) begin
      hist_next = hist_shift;
      if (match && !OVERLAP) begin
        // Non-overlapping mode: the matched bits may not seed the next match
        fill_next = '0;
      end else if (fill_reg != FILL_MAX) begin
        fill_next = fill_reg + 1'b1;
      end
    end
    if (clear) begin
      found_next = 1'b0;
      count_next = '0;
    end else if (match) begin
      found_next = 1'b1;
      if (count_reg != {CNT_W{1'b1}}) begin
        count_next = count_reg + 1'b1;
      end
    end
  end

  // Outputs: out is combinational so it rises with the final pattern bit
  always_comb begin
    out         = match | (STICKY & found_reg);
    found       = found_reg;
    match_count = count_reg;
  end

endmodule
